// File: rtl/console_pkg.sv
// -----------------------------------------------------------------------------
// console_pkg
// Shared definitions for the VGA text console: buffer geometry defaults (also
// used by the scan-out block), control-code constants, the blank cell value
// and the sequencer state encoding.
// -----------------------------------------------------------------------------
package console_pkg;

    // Buffer geometry defaults
    localparam int DEF_NUM_ROWS = 3;
    localparam int DEF_NUM_COLS = 10;
    localparam int DEF_CELL_W   = 9;

    // Control codes (7-bit ASCII)
    localparam logic [6:0] ASCII_BS    = 7'h08;
    localparam logic [6:0] ASCII_LF    = 7'h0A;
    localparam logic [6:0] ASCII_FF    = 7'h0C;
    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_TILDE = 7'h7E;

    // Blank cell: colour 0, space
    localparam logic [8:0] BLANK_CELL = 9'h020;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCROLL  = 2'd1,
        ST_CLR_ROW = 2'd2,
        ST_CLR_ALL = 2'd3
    } state_e;

    // Printable range is SPACE..TILDE inclusive
    function automatic logic is_printable(input logic [6:0] code);
        return (code >= ASCII_SPACE) && (code <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/tqvp_console_ctrl.sv
// -----------------------------------------------------------------------------
// tqvp_console_ctrl
// Terminal-style sequencer for the text console buffer. Accepts characters
// from the host, tracks the cursor, handles CR/LF/BS/FF and runs the
// multi-cycle scroll and clear sequences through the buffer's write port.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   char_valid/char_data    host character offer {color[1:0], code[6:0]}
//   char_ready              character accepted this cycle (IDLE only)
//   cmd_clear               single-cycle clear-screen request
//   buf_we/waddr/wdata      registered buffer write port
//   buf_raddr/buf_rdata     combinational buffer read port (used by scroll)
//   cursor_row/cursor_col   current cursor position
//   busy                    ~char_ready
//   scroll_done             one-cycle pulse with the final scroll write
// -----------------------------------------------------------------------------
module tqvp_console_ctrl
    import console_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int NUM_COLS = DEF_NUM_COLS,
    parameter int CELL_W   = DEF_CELL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              char_valid,
    input  logic [CELL_W-1:0] char_data,
    output logic              char_ready,
    input  logic              cmd_clear,
    output logic              buf_we,
    output logic [4:0]        buf_waddr,
    output logic [CELL_W-1:0] buf_wdata,
    output logic [4:0]        buf_raddr,
    input  logic [CELL_W-1:0] buf_rdata,
    output logic [1:0]        cursor_row,
    output logic [3:0]        cursor_col,
    output logic              busy,
    output logic              scroll_done
);

    localparam logic [4:0] COLS5       = 5'(NUM_COLS);
    localparam logic [4:0] LAST_CELL   = 5'(NUM_ROWS * NUM_COLS - 1);
    localparam logic [4:0] SCROLL_LAST = 5'((NUM_ROWS - 1) * NUM_COLS - 1);
    localparam logic [4:0] LROW_FIRST  = 5'((NUM_ROWS - 1) * NUM_COLS);
    localparam logic [1:0] ROW_LAST    = 2'(NUM_ROWS - 1);
    localparam logic [3:0] COL_LAST    = 4'(NUM_COLS - 1);

    state_e            state_q;
    logic [4:0]        idx_q;
    logic [1:0]        row_q;
    logic [3:0]        col_q;
    logic              clr_pend_q;
    logic              we_q;
    logic [4:0]        waddr_q;
    logic [CELL_W-1:0] wdata_q;
    logic              done_q;

    logic [6:0] code;
    logic [4:0] cur_addr;

    assign code     = char_data[6:0];
    assign cur_addr = 5'(row_q) * COLS5 + 5'(col_q);

    // A pending or fresh clear wins over a character, so the host must not
    // see a handshake in that cycle.
    assign char_ready = (state_q == ST_IDLE) && !cmd_clear && !clr_pend_q;
    assign busy       = ~char_ready;

    // Read ahead one row while scrolling; parked at 0 otherwise.
    assign buf_raddr  = (state_q == ST_SCROLL) ? idx_q + COLS5 : 5'd0;

    assign buf_we      = we_q;
    assign buf_waddr   = waddr_q;
    assign buf_wdata   = wdata_q;
    assign scroll_done = done_q;
    assign cursor_row  = row_q;
    assign cursor_col  = col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLR_ALL;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            clr_pend_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;

            if (cmd_clear && state_q != ST_IDLE)
                clr_pend_q <= 1'b1;

            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_clear || clr_pend_q
                        || (char_valid && code == ASCII_FF)) begin
                        state_q    <= ST_CLR_ALL;
                        idx_q      <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        clr_pend_q <= 1'b0;
                    end else if (char_valid) begin
                        if (is_printable(code)) begin
                            we_q    <= 1'b1;
                            waddr_q <= cur_addr;
                            wdata_q <= char_data;
                            if (col_q == COL_LAST) begin
                                col_q <= '0;
                                if (row_q == ROW_LAST) begin
                                    state_q <= ST_SCROLL;
                                    idx_q   <= '0;
                                end else begin
                                    row_q <= row_q + 2'd1;
                                end
                            end else begin
                                col_q <= col_q + 4'd1;
                            end
                        end else if (code == ASCII_CR) begin
                            col_q <= '0;
                        end else if (code == ASCII_LF) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                state_q <= ST_SCROLL;
                                idx_q   <= '0;
                            end else begin
                                row_q <= row_q + 2'd1;
                            end
                        end else if (code == ASCII_BS) begin
                            if (col_q != '0) begin
                                col_q   <= col_q - 4'd1;
                                we_q    <= 1'b1;
                                waddr_q <= cur_addr - 5'd1;
                                wdata_q <= CELL_W'(BLANK_CELL);
                            end
                        end
                        // other codes are consumed without effect
                    end
                end

                ST_SCROLL: begin
                    we_q    <= 1'b1;
                    waddr_q <= idx_q;
                    wdata_q <= buf_rdata;
                    if (idx_q == SCROLL_LAST) begin
                        state_q <= ST_CLR_ROW;
                        idx_q   <= LROW_FIRST;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end

                ST_CLR_ROW, ST_CLR_ALL: begin
                    we_q    <= 1'b1;
                    waddr_q <= idx_q;
                    wdata_q <= CELL_W'(BLANK_CELL);
                    if (idx_q == LAST_CELL) begin
                        done_q  <= (state_q == ST_CLR_ROW);
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end

                default: state_q <= ST_CLR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_tqvp_console_ctrl.sv
module tb_tqvp_console_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       char_valid;
    logic [8:0] char_data;
    logic       char_ready;
    logic       cmd_clear;
    logic       buf_we;
    logic [4:0] buf_waddr;
    logic [8:0] buf_wdata;
    logic [4:0] buf_raddr;
    logic [8:0] buf_rdata;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;
    logic       scroll_done;

    always #5 clk = ~clk;

    tqvp_console_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .cmd_clear  (cmd_clear),
        .buf_we     (buf_we),
        .buf_waddr  (buf_waddr),
        .buf_wdata  (buf_wdata),
        .buf_raddr  (buf_raddr),
        .buf_rdata  (buf_rdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .scroll_done(scroll_done)
    );

    // Text buffer stand-in: combinational read, synchronous write
    logic [8:0] mem [0:31];
    assign buf_rdata = mem[buf_raddr];
    always @(posedge clk) begin
        if (rst_n && buf_we) mem[buf_waddr] <= buf_wdata;
    end

    typedef struct packed {
        logic [4:0] addr;
        logic [8:0] data;
        logic       done;
    } wr_t;

    wr_t        exp_q[$];
    logic [8:0] ref_scr [0:29];
    int         errors = 0;
    int         checks = 0;
    int         cur_r = 0;
    int         cur_c = 0;

    // Scoreboard monitor: every DUT write must match the next expected one
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (buf_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%h, required no write",
                             buf_waddr, buf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (buf_waddr !== e.addr || buf_wdata !== e.data || scroll_done !== e.done) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%h done=%0b, required addr=%0d data=%h done=%0b",
                                 buf_waddr, buf_wdata, scroll_done, e.addr, e.data, e.done);
                    end else begin
                        $display("write addr=%0d data=%h done=%0b ok", buf_waddr, buf_wdata, scroll_done);
                    end
                end
            end else if (scroll_done) begin
                checks++;
                errors++;
                $display("FAIL stray_scroll_done: got 1 without a write, required 0");
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic push_wr(input int addr, input logic [8:0] data, input logic done);
        wr_t e;
        e.addr = 5'(addr);
        e.data = data;
        e.done = done;
        exp_q.push_back(e);
        ref_scr[addr] = data;
    endtask

    task automatic push_clear();
        for (int i = 0; i < 30; i++) push_wr(i, 9'h020, 1'b0);
    endtask

    task automatic push_scroll();
        for (int i = 0; i < 20; i++) push_wr(i, ref_scr[i + 10], 1'b0);
        for (int i = 20; i < 30; i++) push_wr(i, 9'h020, (i == 29));
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (char_ready === 1'b1) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL timeout_%s: char_ready stayed 0, required 1", tag);
                break;
            end
        end
    endtask

    task automatic drained(input string tag);
        @(negedge clk);
        #1;
        check({"queue_empty_", tag}, exp_q.size(), 0);
    endtask

    // Offer one character; er/ec are the hand-computed cursor afterwards.
    task automatic send(input logic [8:0] d, input int er, input int ec);
        logic [6:0] code;
        bit         scroll;
        code   = d[6:0];
        scroll = 0;
        wait_ready("send");
        char_valid = 1'b1;
        char_data  = d;
        if (code >= 7'h20 && code <= 7'h7E) begin
            push_wr(cur_r * 10 + cur_c, d, 1'b0);
            if (cur_c == 9 && cur_r == 2) scroll = 1;
        end else if (code == 7'h0A) begin
            if (cur_r == 2) scroll = 1;
        end else if (code == 7'h08) begin
            if (cur_c > 0) push_wr(cur_r * 10 + cur_c - 1, 9'h020, 1'b0);
        end else if (code == 7'h0C) begin
            push_clear();
        end
        if (scroll) push_scroll();
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        check($sformatf("row_after_%h", d), 32'(cursor_row), 32'(er));
        check($sformatf("col_after_%h", d), 32'(cursor_col), 32'(ec));
        cur_r = er;
        cur_c = ec;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 9'h000;
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = 9'h000;
        cmd_clear  = 1'b0;
        push_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(char_ready), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_we", 32'(buf_we), 0);
        check("rst_row", 32'(cursor_row), 0);
        check("rst_col", 32'(cursor_col), 0);
        #2 rst_n = 1'b1;

        // Power-up clear, then ready at (0,0)
        wait_ready("init");
        check("init_busy", 32'(busy), 0);
        drained("init");

        // 'A' colour 2 at (0,0); write must be visible the cycle after accept
        send(9'h141, 0, 1);
        check("lat_we", 32'(buf_we), 1);
        check("lat_addr", 32'(buf_waddr), 0);
        check("lat_data", 32'(buf_wdata), 32'h141);

        // Fill rest of row 0: 10th write at addr 9 wraps to (1,0)
        for (int i = 1; i < 10; i++)
            send(9'h041 + 9'(i), (i == 9) ? 1 : 0, (i == 9) ? 0 : i + 1);

        // CR, BS at column 0, BS mid-row
        send(9'h078, 1, 1);
        send(9'h079, 1, 2);
        send(9'h00D, 1, 0);
        send(9'h008, 1, 0);
        send(9'h061, 1, 1);
        send(9'h062, 1, 2);
        send(9'h063, 1, 3);
        send(9'h008, 1, 2);
        drained("bs");

        // LF to row 2, fill row 2; last printable at addr 29 scrolls
        send(9'h00A, 2, 0);
        for (int i = 0; i < 10; i++) send(9'h0B0 + 9'(i), 2, (i == 9) ? 0 : i + 1);
        wait_ready("scroll1");
        drained("scroll1");

        // LF on last row scrolls without a character write
        send(9'h00A, 2, 0);
        wait_ready("scroll2");
        drained("scroll2");

        // FF, with cmd_clear pulsed during the clear: a second clear follows
        send(9'h00C, 0, 0);
        @(negedge clk);
        cmd_clear = 1'b1;
        push_clear();
        @(negedge clk);
        cmd_clear = 1'b0;
        wait_ready("pend");
        drained("pend");

        // cmd_clear and char_valid together: clear first, char after
        wait_ready("combo");
        cmd_clear  = 1'b1;
        char_valid = 1'b1;
        char_data  = 9'h05A;
        #1;
        check("combo_ready", 32'(char_ready), 0);
        push_clear();
        push_wr(0, 9'h05A, 1'b0);
        @(posedge clk);
        #1;
        cmd_clear = 1'b0;
        wait_ready("combo2");
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        check("combo_row", 32'(cursor_row), 0);
        check("combo_col", 32'(cursor_col), 1);
        cur_r = 0;
        cur_c = 1;
        drained("combo");

        // Unknown control code: accepted, nothing happens
        send(9'h001, 0, 1);
        drained("other");

        // Start a scroll, then reset in the middle of it
        send(9'h00A, 1, 0);
        send(9'h00A, 2, 0);
        send(9'h00A, 2, 0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(buf_we), 0);
        check("mid_rst_done", 32'(scroll_done), 0);
        check("mid_rst_ready", 32'(char_ready), 0);
        check("mid_rst_busy", 32'(busy), 1);
        check("mid_rst_addr", 32'(buf_waddr), 0);
        check("mid_rst_row", 32'(cursor_row), 0);
        exp_q.delete();
        push_clear();
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_ready("rerun");
        check("rerun_row", 32'(cursor_row), 0);
        check("rerun_col", 32'(cursor_col), 0);
        drained("rerun");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
